// File: rtl/pbus_arbiter_if.sv
// rtl/pbus_arbiter_if.sv - request/response and bridge-side signal bundle for pbus_arbiter
// The "slave" modport is the arbiter's view; "master" is the surrounding masters plus bridge port.
interface pbus_arbiter_if;
  logic        m0_req;
  logic        m1_req;
  logic        m0_we;
  logic        m1_we;
  logic [31:0] m0_addr;
  logic [31:0] m1_addr;
  logic [31:0] m0_wd;
  logic [31:0] m1_wd;
  logic        m0_ack;
  logic        m1_ack;
  logic [31:0] m0_rd;
  logic [31:0] m1_rd;
  logic        err;
  logic [31:0] s_addr;
  logic [31:0] s_wd;
  logic        s_we;
  logic [31:0] s_rd;
  logic        s_rdy;
  logic        gnt_id;
  logic        busy;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wd, m1_wd, s_rd, s_rdy,
    output m0_ack, m1_ack, m0_rd, m1_rd, err, s_addr, s_wd, s_we, gnt_id, busy
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wd, m1_wd, s_rd, s_rdy,
    input  m0_ack, m1_ack, m0_rd, m1_rd, err, s_addr, s_wd, s_we, gnt_id, busy
  );
endinterface

// File: rtl/pbus_arbiter.sv
// rtl/pbus_arbiter.sv - two-master peripheral-bus arbiter, fixed priority to m0 with starvation limit
// Grants one master, drives the latched request to the bridge, returns data with a one-cycle ack.
module pbus_arbiter #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned TMO  = 15
) (
  input  logic          clk,
  input  logic          reset,
  pbus_arbiter_if.slave bus
);

  localparam logic [3:0] HOLD_C = 4'(HOLD);
  localparam logic [7:0] TMO_C  = 8'(TMO);

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        grant;
  logic        pick_m1;
  logic        timeout;
  logic [3:0]  hold_cnt;
  logic [7:0]  wait_cnt;
  logic [31:0] s_addr_q;
  logic [31:0] s_wd_q;
  logic        s_we_q;
  logic        gnt_q;
  logic [31:0] resp_q;
  logic        err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    pick_m1   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          grant     = 1'b1;
          pick_m1   = bus.m1_req && (!bus.m0_req || hold_cnt == HOLD_C);
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (bus.s_rdy) begin
          state_nxt = RESP;
        end else if (wait_cnt == TMO_C) begin
          timeout   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // s_we is cleared on leaving ADDR so a write is presented only while the slave can accept it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_addr_q <= '0;
      s_wd_q   <= '0;
      s_we_q   <= 1'b0;
      gnt_q    <= 1'b0;
      wait_cnt <= '0;
      hold_cnt <= '0;
      resp_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (grant) begin
        gnt_q    <= pick_m1;
        s_addr_q <= pick_m1 ? bus.m1_addr : bus.m0_addr;
        s_wd_q   <= pick_m1 ? bus.m1_wd   : bus.m0_wd;
        s_we_q   <= pick_m1 ? bus.m1_we   : bus.m0_we;
        wait_cnt <= '0;
      end
      if (state == ADDR) begin
        if (bus.s_rdy) begin
          resp_q <= s_we_q ? 32'h0 : bus.s_rd;
          err_q  <= 1'b0;
          s_we_q <= 1'b0;
        end else if (timeout) begin
          resp_q <= '0;
          err_q  <= 1'b1;
          s_we_q <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
      // Starvation counter only tracks m0 wins that happened while m1 was waiting.
      if (state == IDLE) begin
        if (!bus.m1_req || (grant && pick_m1)) begin
          hold_cnt <= '0;
        end else if (grant && hold_cnt != HOLD_C) begin
          hold_cnt <= hold_cnt + 4'd1;
        end
      end
    end
  end

  assign bus.s_addr = s_addr_q;
  assign bus.s_wd   = s_wd_q;
  assign bus.s_we   = s_we_q;
  assign bus.gnt_id = gnt_q;
  assign bus.busy   = (state != IDLE);
  assign bus.m0_ack = (state == RESP) && !gnt_q;
  assign bus.m1_ack = (state == RESP) && gnt_q;
  assign bus.m0_rd  = bus.m0_ack ? resp_q : 32'h0;
  assign bus.m1_rd  = bus.m1_ack ? resp_q : 32'h0;
  assign bus.err    = (state == RESP) && err_q;

endmodule

// File: tb/tb_pbus_arbiter.sv
// tb/tb_pbus_arbiter.sv - directed self-checking bench for pbus_arbiter
// Inputs change and outputs are sampled on the falling edge.
module tb_pbus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  pbus_arbiter_if bus ();

  pbus_arbiter #(.HOLD(4), .TMO(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_busy(output int ok);
    ok = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  int n;
  int ok;
  int cnt;
  logic exp_who [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    bus.m0_req = 0; bus.m1_req = 0; bus.m0_we = 0; bus.m1_we = 0;
    bus.m0_addr = 0; bus.m1_addr = 0; bus.m0_wd = 0; bus.m1_wd = 0;
    bus.s_rd = 0; bus.s_rdy = 1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_m0_ack", 32'(bus.m0_ack), 0);
    check("rst_m1_ack", 32'(bus.m1_ack), 0);
    check("rst_s_we", 32'(bus.s_we), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_s_addr", bus.s_addr, 0);
    check("rst_gnt", 32'(bus.gnt_id), 0);
    reset = 1'b1;

    // Single read from m0
    @(negedge clk);
    bus.s_rd = 32'h1234_5678;
    bus.m0_addr = 32'h7F04; bus.m0_we = 0; bus.m0_req = 1;
    @(negedge clk);
    check("rd_s_addr", bus.s_addr, 32'h7F04);
    check("rd_busy", 32'(bus.busy), 1);
    check("rd_s_we_addr", 32'(bus.s_we), 0);
    @(negedge clk);
    check("rd_m0_ack", 32'(bus.m0_ack), 1);
    check("rd_m0_rd", bus.m0_rd, 32'h1234_5678);
    check("rd_err", 32'(bus.err), 0);
    check("rd_s_we_resp", 32'(bus.s_we), 0);
    bus.m0_req = 0;
    @(negedge clk);
    check("rd_idle_ack", 32'(bus.m0_ack), 0);
    check("rd_idle_busy", 32'(bus.busy), 0);

    // Single write from m1
    bus.m1_addr = 32'h7F10; bus.m1_wd = 32'hDEAD_BEEF; bus.m1_we = 1; bus.m1_req = 1;
    @(negedge clk);
    check("wr_s_we", 32'(bus.s_we), 1);
    check("wr_s_wd", bus.s_wd, 32'hDEAD_BEEF);
    check("wr_s_addr", bus.s_addr, 32'h7F10);
    check("wr_gnt", 32'(bus.gnt_id), 1);
    @(negedge clk);
    check("wr_s_we_resp", 32'(bus.s_we), 0);
    check("wr_m1_ack", 32'(bus.m1_ack), 1);
    check("wr_m0_ack", 32'(bus.m0_ack), 0);
    check("wr_m1_rd", bus.m1_rd, 0);
    bus.m1_req = 0; bus.m1_we = 0;
    @(negedge clk);
    check("wr_idle_ack", 32'(bus.m1_ack), 0);

    // Contention: both requests held continuously
    bus.m0_addr = 32'h100; bus.m1_addr = 32'h200;
    bus.m0_req = 1; bus.m1_req = 1;
    for (int t = 0; t < 10; t++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!bus.m0_ack && !bus.m1_ack && cnt < 10);
      check($sformatf("cont_spacing_%0d", t), cnt, (t == 0) ? 2 : 3);
      check($sformatf("cont_who_%0d", t), 32'(bus.m1_ack), 32'(exp_who[t]));
      check($sformatf("cont_one_%0d", t), 32'(bus.m0_ack ^ bus.m1_ack), 1);
    end
    bus.m0_req = 0; bus.m1_req = 0;
    @(negedge clk);

    // Slave stall of 5 cycles, then ready
    bus.s_rdy = 0; bus.s_rd = 32'h0;
    bus.m0_addr = 32'h7F08; bus.m0_req = 1;
    wait_busy(ok);
    check("stall_grant", 32'(ok), 1);
    n = 1;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (bus.m0_ack) break;
      if (n == 6) begin
        bus.s_rdy = 1; bus.s_rd = 32'hA5A5_A5A5;
      end
    end
    check("stall_latency", n, 7);
    check("stall_rd", bus.m0_rd, 32'hA5A5_A5A5);
    check("stall_err", 32'(bus.err), 0);
    bus.m0_req = 0;
    @(negedge clk);

    // Timeout with s_rdy held low
    bus.s_rdy = 0; bus.s_rd = 32'hFFFF_0000;
    bus.m1_addr = 32'h7F0C; bus.m1_we = 0; bus.m1_req = 1;
    wait_busy(ok);
    check("tmo_grant", 32'(ok), 1);
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.m1_ack) break;
    end
    check("tmo_latency", n, 17);
    check("tmo_err", 32'(bus.err), 1);
    check("tmo_rd", bus.m1_rd, 0);
    bus.m1_req = 0;
    @(negedge clk);
    check("tmo_err_clear", 32'(bus.err), 0);

    // Reset during ADDR of a pending write
    bus.m0_addr = 32'h7F20; bus.m0_wd = 32'h55AA_55AA; bus.m0_we = 1; bus.m0_req = 1;
    wait_busy(ok);
    check("rstw_grant", 32'(ok), 1);
    check("rstw_s_we_before", 32'(bus.s_we), 1);
    #2 reset = 1'b0;
    #1;
    check("rstw_s_we_now", 32'(bus.s_we), 0);
    check("rstw_busy_now", 32'(bus.busy), 0);
    repeat (2) begin
      @(negedge clk);
      check("rstw_no_ack", 32'(bus.m0_ack), 0);
    end
    reset = 1'b1; bus.s_rdy = 1;
    #1;
    check("rstw_rel_s_addr", bus.s_addr, 0);
    check("rstw_rel_s_wd", bus.s_wd, 0);
    check("rstw_rel_err", 32'(bus.err), 0);
    check("rstw_rel_rd", bus.m0_rd, 0);
    @(negedge clk);
    check("rstw_regrant_busy", 32'(bus.busy), 1);
    check("rstw_regrant_addr", bus.s_addr, 32'h7F20);
    check("rstw_regrant_we", 32'(bus.s_we), 1);
    @(negedge clk);
    check("rstw_ack", 32'(bus.m0_ack), 1);
    bus.m0_req = 0; bus.m0_we = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
